// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the byte-serial MAC sequencer.
// Pin bit positions are fixed by the board wiring of the shared uio bus.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam int IN_VALID_BIT  = 0;
    localparam int READY_BIT     = 1;
    localparam int OUT_ACK_BIT   = 2;
    localparam int OUT_VALID_BIT = 7;

    localparam logic [7:0] UIO_OE_VAL = 8'h82;

    // Number of result bytes needed to carry an acc_w-bit accumulator.
    function automatic int out_bytes(input int acc_w);
        return (acc_w + 7) / 8;
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_mac_unit.sv
// Signed 8x8 multiplier feeding a wrapping ACC_W-bit accumulator.
// clear_load replaces the accumulator with the current product instead of adding.
module mac_unit #(
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clear_load,
    input  logic signed [7:0]       a,
    input  logic signed [7:0]       b,
    output logic        [ACC_W-1:0] acc
);

    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic        [ACC_W-1:0] acc_q;
    logic        [ACC_W-1:0] acc_d;

    always_comb begin
        prod     = a * b;
        prod_ext = ACC_W'(prod);
        acc_d    = acc_q;
        if (en) begin
            if (clear_load) begin
                acc_d = prod_ext;
            end else begin
                acc_d = acc_q + prod_ext;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Byte-serial dot-product sequencer: loads N_ELEM operand pairs, runs the MAC,
// then returns the sign-extended result LSB first under a valid/ack handshake.
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int N_ELEM = 4,
    parameter int ACC_W  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int OUT_BYTES = out_bytes(ACC_W);
    localparam int EXT_W     = 8 * OUT_BYTES;
    localparam int EW        = $clog2(N_ELEM);
    localparam int IDX_W     = $clog2(2 * N_ELEM + OUT_BYTES);

    // Handshake: a byte moves on a rising edge only when both sides of its
    // pair are high in that cycle (ready & in_valid for loads, out_valid &
    // out_ack for results); ena low blocks both.
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         a_q [N_ELEM];
    logic [7:0]         b_q [N_ELEM];
    logic [7:0]         a_d [N_ELEM];
    logic [7:0]         b_d [N_ELEM];

    logic               in_valid, out_ack;
    logic               ready, out_valid, accept;
    logic               mac_en, mac_clear;
    logic [EW-1:0]      ld_elem, mac_elem;
    logic [ACC_W-1:0]   acc;
    logic [EXT_W-1:0]   acc_ext;
    logic [EXT_W-1:0]   acc_sh;

    assign in_valid  = uio_in[IN_VALID_BIT];
    assign out_ack   = uio_in[OUT_ACK_BIT];
    assign ld_elem   = idx_q[EW:1];
    assign mac_elem  = idx_q[EW-1:0];
    assign ready     = ena & ~rst & (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_OUT);
    assign accept    = ready & in_valid;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        mac_en    = 1'b0;
        mac_clear = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    // Even index carries a[i], odd index carries b[i].
                    if (idx_q[0]) begin
                        b_d[ld_elem] = ui_in;
                    end else begin
                        a_d[ld_elem] = ui_in;
                    end
                    if (idx_q == IDX_W'(2 * N_ELEM - 1)) begin
                        state_d = ST_MAC;
                        idx_d   = '0;
                    end else begin
                        idx_d = IDX_W'(idx_q + 1'b1);
                    end
                end
            end
            ST_MAC: begin
                if (ena) begin
                    mac_en    = 1'b1;
                    mac_clear = (idx_q == '0);
                    if (idx_q == IDX_W'(N_ELEM - 1)) begin
                        state_d = ST_OUT;
                        idx_d   = '0;
                    end else begin
                        idx_d = IDX_W'(idx_q + 1'b1);
                    end
                end
            end
            ST_OUT: begin
                if (ena && out_ack) begin
                    if (idx_q == IDX_W'(OUT_BYTES - 1)) begin
                        state_d = ST_LOAD;
                        idx_d   = '0;
                    end else begin
                        idx_d = IDX_W'(idx_q + 1'b1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Operand storage is deliberately not reset; every slot is rewritten before use.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    mac_unit #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .en         (mac_en),
        .clear_load (mac_clear),
        .a          (a_q[mac_elem]),
        .b          (b_q[mac_elem]),
        .acc        (acc)
    );

    always_comb begin
        acc_ext = EXT_W'($signed(acc));
        acc_sh  = acc_ext >> {idx_q, 3'b000};
        uo_out  = out_valid ? acc_sh[7:0] : 8'h00;
        uio_out = 8'h00;
        uio_out[READY_BIT]     = ready;
        uio_out[OUT_VALID_BIT] = out_valid;
    end

    assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: table of dot-product vectors plus
// hand-written stall, freeze and mid-operation reset sequences.
module tb_mac_seq_ctrl;

    localparam int N_ELEM = 4;
    localparam int ACC_W  = 20;
    localparam int NB     = 3;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total;
    int bad;
    int cyc;
    int last_acc;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [5];

    mac_seq_ctrl #(
        .N_ELEM (N_ELEM),
        .ACC_W  (ACC_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        int n;
        ui_in     = v;
        uio_in[0] = 1'b1;
        n = 0;
        #1;
        while (!uio_out[1] && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
        tick();
        last_acc  = cyc;
        uio_in[0] = 1'b0;
        ui_in     = 8'h00;
    endtask

    task automatic freeze_load();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            uio_in[0] = i[0] ? 1'b0 : 1'b1;
            ui_in     = 8'hAA;
            #1;
            chk("frozen_ready", {24'd0, uio_out}, 32'h00);
            tick();
        end
        uio_in[0] = 1'b0;
        ena       = 1'b1;
    endtask

    task automatic send_vec(input logic [31:0] a, input logic [31:0] b, input bit freeze);
        for (int i = 0; i < N_ELEM; i++) begin
            if (freeze && i == 1) freeze_load();
            send_byte(a[8*i +: 8]);
            send_byte(b[8*i +: 8]);
        end
    endtask

    task automatic recv_vec(input logic [23:0] exp, input bit stall);
        int n;
        n = 0;
        while (!uio_out[7] && n < 40) begin
            tick();
            n++;
        end
        chk("out_valid_latency", cyc - last_acc, N_ELEM);
        for (int k = 0; k < NB; k++) begin
            if (stall && k == 0) begin
                uio_in[2] = 1'b0;
                repeat (5) tick();
                chk("stall_byte", {24'd0, uo_out}, {24'd0, exp[7:0]});
                ena       = 1'b0;
                uio_in[2] = 1'b1;
                repeat (2) tick();
                chk("frozen_ack_byte", {24'd0, uo_out}, {24'd0, exp[7:0]});
                chk("frozen_out_valid", {31'd0, uio_out[7]}, 32'd1);
                uio_in[2] = 1'b0;
                ena       = 1'b1;
                #1;
            end
            chk("out_valid", {31'd0, uio_out[7]}, 32'd1);
            chk("out_byte", {24'd0, uo_out}, {24'd0, exp[8*k +: 8]});
            uio_in[2] = 1'b1;
            tick();
            uio_in[2] = 1'b0;
        end
        chk("ready_after_last_ack", {24'd0, uio_out}, 32'h02);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;
        rst    = 1'b1;

        vecs[0] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5}, exp: 24'h000046};
        vecs[1] = '{a: {4{8'h80}}, b: {4{8'h80}}, exp: 24'h010000};
        vecs[2] = '{a: {4{8'hFF}}, b: {4{8'h01}}, exp: 24'hFFFFFC};
        vecs[3] = '{a: {4{8'h7F}}, b: {4{8'h80}}, exp: 24'hFF0200};
        vecs[4] = '{a: {8'hD8, 8'h1E, 8'hEC, 8'h0A}, b: {8'h09, 8'hF9, 8'h05, 8'h03}, exp: 24'hFFFD80};

        repeat (3) tick();
        chk("reset_uo_out", {24'd0, uo_out}, 32'h00);
        chk("reset_uio_oe", {24'd0, uio_oe}, 32'h82);
        chk("reset_uio_out", {24'd0, uio_out}, 32'h00);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", {24'd0, uio_out}, 32'h02);
        chk("uo_out_after_reset", {24'd0, uo_out}, 32'h00);

        for (int v = 0; v < 5; v++) begin
            send_vec(vecs[v].a, vecs[v].b, 1'b0);
            recv_vec(vecs[v].exp, 1'b0);
        end

        // Output stall plus ena freeze during OUT.
        send_vec(vecs[0].a, vecs[0].b, 1'b0);
        recv_vec(vecs[0].exp, 1'b1);

        // ena dropped mid-LOAD while in_valid pulses.
        send_vec(vecs[0].a, vecs[0].b, 1'b1);
        recv_vec(vecs[0].exp, 1'b0);

        // Reset asserted during MAC.
        send_vec(vecs[0].a, vecs[0].b, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_mac_reset_uio_out", {24'd0, uio_out}, 32'h00);
        chk("mid_mac_reset_uo_out", {24'd0, uo_out}, 32'h00);
        tick();
        rst = 1'b0;
        tick();
        chk("ready_after_mid_reset", {24'd0, uio_out}, 32'h02);
        send_vec({4{8'd2}}, {4{8'd3}}, 1'b0);
        recv_vec(24'h000018, 1'b0);

        // Reset with only part of the operands loaded.
        send_byte(8'd9);
        send_byte(8'd9);
        send_byte(8'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_vec({4{8'd2}}, {4{8'd3}}, 1'b0);
        recv_vec(24'h000018, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
